// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_sequencer
//  Description : Run controller and hazard unit for the 5-stage F/D/E/M/W
//                vector filter pipeline (start, stall, forward, drain, done).
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_sequencer #(
  parameter int RA_W         = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             haltd,
  input  logic [RA_W-1:0]  ra1d,
  input  logic [RA_W-1:0]  ra2d,
  input  logic [RA_W-1:0]  ra1e,
  input  logic [RA_W-1:0]  ra2e,
  input  logic [RA_W-1:0]  wa3e,
  input  logic [RA_W-1:0]  wa3m,
  input  logic [RA_W-1:0]  wa3w,
  input  logic             memtorege,
  input  logic             regwritem,
  input  logic             regwritew,
  output logic             en1,
  output logic             en2,
  output logic             clr1,
  output logic             clr2,
  output logic             pcclr,
  output logic [1:0]       forwardae,
  output logic [1:0]       forwardbe,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cyclecount,
  output logic [CNT_W-1:0] stallcount
);

  localparam int                 c_drn_w    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_drn_w-1:0] c_drn_load = c_drn_w'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_drn_w-1:0] r_drn;
  logic               r_pcclr;
  logic [CNT_W-1:0]   r_cyc;
  logic [CNT_W-1:0]   r_stl;
  logic               w_stall;
  logic               w_launch;

  // M-stage result is younger than W, so it wins when both match
  always_comb begin
    forwardae = 2'b00;
    forwardbe = 2'b00;
    if (regwritem && (wa3m == ra1e))      forwardae = 2'b10;
    else if (regwritew && (wa3w == ra1e)) forwardae = 2'b01;
    if (regwritem && (wa3m == ra2e))      forwardbe = 2'b10;
    else if (regwritew && (wa3w == ra2e)) forwardbe = 2'b01;
  end

  assign w_stall  = memtorege && ((wa3e == ra1d) || (wa3e == ra2d));
  assign w_launch = (r_state == S_IDLE) && start;

  always_comb begin
    w_state_nxt = r_state;
    en1         = 1'b0;
    en2         = 1'b0;
    clr1        = 1'b1;
    clr2        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        en1  = ~w_stall;
        en2  = ~w_stall;
        clr1 = 1'b0;
        clr2 = w_stall;
        if (haltd && !w_stall) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drn <= c_drn_w'(1)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pcclr <= 1'b0;
      r_drn   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pcclr <= w_launch;
      if ((r_state == S_RUN) && (w_state_nxt == S_DRAIN)) begin
        r_drn <= c_drn_load;
      end else if ((r_state == S_DRAIN) && (r_drn != '0)) begin
        r_drn <= r_drn - c_drn_w'(1);
      end
    end
  end

  // Counters saturate and hold through IDLE until the next launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
      r_stl <= '0;
    end else if (w_launch) begin
      r_cyc <= '0;
      r_stl <= '0;
    end else begin
      if (((r_state == S_RUN) || (r_state == S_DRAIN)) && !(&r_cyc)) begin
        r_cyc <= r_cyc + CNT_W'(1);
      end
      if ((r_state == S_RUN) && w_stall && !(&r_stl)) begin
        r_stl <= r_stl + CNT_W'(1);
      end
    end
  end

  assign pcclr      = r_pcclr;
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign cyclecount = r_cyc;
  assign stallcount = r_stl;

endmodule
`default_nettype wire
